// File: rtl/seq_pkg.sv
// Shared types and default sizes for the bit-serial operation sequencer.
package seq_pkg;

  localparam int unsigned DefaultWidth = 4;
  localparam int unsigned DefaultDepth = 4;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone,
    StHold
  } state_t;

  typedef struct packed {
    logic [2:0] f;
    logic [1:0] r;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command queue for the sequencer: synchronous FIFO with full/empty and occupancy count.
module cmd_fifo
  import seq_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  cmd_t                       data_i,
  input  logic                       pop_i,
  output cmd_t                       data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  cmd_t            mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  // Full-cycle pushes are dropped even if a pop frees a slot in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_op_sequencer.sv
// Sequencer for the 4-bit bit-serial logic datapath: queues F/R commands, turns button
// levels into load strobes and drives WIDTH shift cycles per operation.
module serial_op_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       load_a_i,
  input  logic                       load_b_i,
  input  logic                       execute_i,
  input  logic                       run_all_i,
  input  logic                       cmd_valid_i,
  input  logic [2:0]                 cmd_f_i,
  input  logic [1:0]                 cmd_r_i,
  output logic                       cmd_ready_o,
  output logic                       ld_a_o,
  output logic                       ld_b_o,
  output logic                       shift_en_o,
  output logic [2:0]                 f_out_o,
  output logic [1:0]                 r_out_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_empty_o,
  output logic [$clog2(DEPTH+1)-1:0] q_count_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_t          state_q;
  logic [CntW-1:0] cnt_q;
  logic            load_a_q, load_b_q, execute_q;
  logic            ld_a_q, ld_b_q, shift_en_q, busy_q, done_q, err_empty_q;
  logic [2:0]      f_q;
  logic [1:0]      r_q;

  logic            load_a_rise, load_b_rise, execute_rise;
  logic            pop_req;
  logic            fifo_full, fifo_empty;
  cmd_t            cmd_in, cmd_head;

  assign load_a_rise  = load_a_i && !load_a_q;
  assign load_b_rise  = load_b_i && !load_b_q;
  assign execute_rise = execute_i && !execute_q;

  assign cmd_in = '{f: cmd_f_i, r: cmd_r_i};

  // A pop starts an operation: first one on an Execute edge, later ones chained in Run_All mode.
  always_comb begin
    pop_req = 1'b0;
    if (!fifo_empty) begin
      if (state_q == StIdle && execute_rise) pop_req = 1'b1;
      if (state_q == StDone && run_all_i)    pop_req = 1'b1;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .data_i  (cmd_in),
    .pop_i   (pop_req),
    .data_o  (cmd_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_count_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      execute_q   <= 1'b0;
      ld_a_q      <= 1'b0;
      ld_b_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_empty_q <= 1'b0;
      f_q         <= 3'b000;
      r_q         <= 2'b00;
    end else begin
      load_a_q    <= load_a_i;
      load_b_q    <= load_b_i;
      execute_q   <= execute_i;
      ld_a_q      <= 1'b0;
      ld_b_q      <= 1'b0;
      done_q      <= 1'b0;
      err_empty_q <= 1'b0;

      if (pop_req) begin
        f_q        <= cmd_head.f;
        r_q        <= cmd_head.r;
        cnt_q      <= '0;
        shift_en_q <= 1'b1;
        busy_q     <= 1'b1;
        state_q    <= StShift;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (execute_rise) begin
              err_empty_q <= 1'b1;
              state_q     <= StHold;
            end else begin
              ld_a_q <= load_a_rise;
              ld_b_q <= load_b_rise;
            end
          end
          StShift: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              shift_en_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StDone;
            end
          end
          StDone: begin
            busy_q  <= 1'b0;
            state_q <= StHold;
          end
          StHold: begin
            if (!execute_i) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign cmd_ready_o = !fifo_full;
  assign ld_a_o      = ld_a_q;
  assign ld_b_o      = ld_b_q;
  assign shift_en_o  = shift_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_empty_o = err_empty_q;
  assign f_out_o     = f_q;
  assign r_out_o     = r_q;

endmodule

// File: tb/tb_serial_op_sequencer.sv
// Directed, table-driven bench for serial_op_sequencer plus hand sequences for Run_All,
// queue-full and mid-shift reset behaviour.
module tb_serial_op_sequencer;

  logic       clk, rst_n;
  logic       load_a, load_b, execute, run_all, cmd_valid;
  logic [2:0] cmd_f;
  logic [1:0] cmd_r;
  logic       cmd_ready, ld_a, ld_b, shift_en, busy, done, err_empty;
  logic [2:0] f_out;
  logic [1:0] r_out;
  logic [2:0] q_count;

  int checks = 0;
  int errors = 0;

  serial_op_sequencer #(
    .WIDTH (4),
    .DEPTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_a_i    (load_a),
    .load_b_i    (load_b),
    .execute_i   (execute),
    .run_all_i   (run_all),
    .cmd_valid_i (cmd_valid),
    .cmd_f_i     (cmd_f),
    .cmd_r_i     (cmd_r),
    .cmd_ready_o (cmd_ready),
    .ld_a_o      (ld_a),
    .ld_b_o      (ld_b),
    .shift_en_o  (shift_en),
    .f_out_o     (f_out),
    .r_out_o     (r_out),
    .busy_o      (busy),
    .done_o      (done),
    .err_empty_o (err_empty),
    .q_count_o   (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {ld_a, ld_b, shift_en, busy, done, err_empty, cmd_ready, q_count, f, r}
  typedef struct {
    logic        la, lb, ex, ra, cv;
    logic [2:0]  cf;
    logic [1:0]  cr;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] pk(input logic a, b, sh, bs, dn, er, rdy,
                                     input logic [2:0] q, input logic [2:0] f,
                                     input logic [1:0] r);
    return {a, b, sh, bs, dn, er, rdy, q, f, r};
  endfunction

  function automatic logic [14:0] outs();
    return {ld_a, ld_b, shift_en, busy, done, err_empty, cmd_ready, q_count, f_out, r_out};
  endfunction

  task automatic add(input logic la, lb, ex, ra, cv, input logic [2:0] cf,
                     input logic [1:0] cr, input logic [14:0] exp);
    vec_t v;
    v.la = la; v.lb = lb; v.ex = ex; v.ra = ra; v.cv = cv; v.cf = cf; v.cr = cr; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic la, lb, ex, ra, cv, input logic [2:0] cf,
                       input logic [1:0] cr);
    load_a = la; load_b = lb; execute = ex; run_all = ra; cmd_valid = cv;
    cmd_f = cf; cmd_r = cr;
  endtask

  localparam logic [14:0] RstOut = 15'b000000_1_000_000_00;

  logic [2:0] exp_f [3];

  initial begin
    drive(0, 0, 0, 0, 0, 3'b000, 2'b00);
    rst_n = 1'b0;
    #3;
    chk("reset_state", outs(), RstOut);
    #10 rst_n = 1'b1;

    // Single operation held Execute, then a second press
    add(0,0,0,0,1,3'b010,2'b10, pk(0,0,0,0,0,0,1,3'd1,3'b000,2'b00));
    for (int i = 0; i < 4; i++)
      add(0,0,1,0,0,3'b000,2'b00, pk(0,0,1,1,0,0,1,3'd0,3'b010,2'b10));
    add(0,0,1,0,0,3'b000,2'b00, pk(0,0,0,1,1,0,1,3'd0,3'b010,2'b10));
    for (int i = 0; i < 6; i++)
      add(0,0,1,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b010,2'b10));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b010,2'b10));
    add(0,0,0,0,1,3'b110,2'b01, pk(0,0,0,0,0,0,1,3'd1,3'b010,2'b10));
    for (int i = 0; i < 4; i++)
      add(0,0,1,0,0,3'b000,2'b00, pk(0,0,1,1,0,0,1,3'd0,3'b110,2'b01));
    add(0,0,1,0,0,3'b000,2'b00, pk(0,0,0,1,1,0,1,3'd0,3'b110,2'b01));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b110,2'b01));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b110,2'b01));
    // Execute with empty queue
    add(0,0,1,0,0,3'b000,2'b00, pk(0,0,0,0,0,1,1,3'd0,3'b110,2'b01));
    add(0,0,1,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b110,2'b01));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b110,2'b01));
    // LoadA held four cycles
    add(1,0,0,0,0,3'b000,2'b00, pk(1,0,0,0,0,0,1,3'd0,3'b110,2'b01));
    for (int i = 0; i < 3; i++)
      add(1,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b110,2'b01));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b110,2'b01));
    // LoadB during SHIFT is dropped
    add(0,0,0,0,1,3'b001,2'b00, pk(0,0,0,0,0,0,1,3'd1,3'b110,2'b01));
    add(0,0,1,0,0,3'b000,2'b00, pk(0,0,1,1,0,0,1,3'd0,3'b001,2'b00));
    add(0,1,1,0,0,3'b000,2'b00, pk(0,0,1,1,0,0,1,3'd0,3'b001,2'b00));
    add(0,1,1,0,0,3'b000,2'b00, pk(0,0,1,1,0,0,1,3'd0,3'b001,2'b00));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,1,1,0,0,1,3'd0,3'b001,2'b00));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,1,1,0,1,3'd0,3'b001,2'b00));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b001,2'b00));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b001,2'b00));
    // LoadA together with Execute edge: Execute wins
    add(1,0,1,0,0,3'b000,2'b00, pk(0,0,0,0,0,1,1,3'd0,3'b001,2'b00));
    add(0,0,0,0,0,3'b000,2'b00, pk(0,0,0,0,0,0,1,3'd0,3'b001,2'b00));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].la, vecs[i].lb, vecs[i].ex, vecs[i].ra, vecs[i].cv, vecs[i].cf, vecs[i].cr);
      tick();
      chk($sformatf("vec_%0d", i), outs(), vecs[i].exp);
    end

    // Run_All drain of three commands
    exp_f[0] = 3'b010; exp_f[1] = 3'b110; exp_f[2] = 3'b000;
    drive(0,0,0,1,1,3'b010,2'b10); tick();
    drive(0,0,0,1,1,3'b110,2'b01); tick();
    drive(0,0,0,1,1,3'b000,2'b11); tick();
    chk("runall_q3", {12'd0, q_count}, 15'd3);
    drive(0,0,1,1,0,3'b000,2'b00); tick();
    execute = 1'b0;
    for (int op = 0; op < 3; op++) begin
      for (int c = 0; c < 4; c++) begin
        if (!(op == 0 && c == 0)) tick();
        chk($sformatf("runall_shift_%0d_%0d", op, c), {9'd0, shift_en, busy, f_out, done},
            {9'd0, 1'b1, 1'b1, exp_f[op], 1'b0});
      end
      tick();
      chk($sformatf("runall_done_%0d", op), {9'd0, shift_en, done, q_count, busy},
          {9'd0, 1'b0, 1'b1, 3'(2 - op), 1'b1});
    end
    tick();
    chk("runall_end", outs(), pk(0,0,0,0,0,0,1,3'd0,3'b000,2'b11));
    tick();
    run_all = 1'b0;

    // Queue full: five pushes, fifth dropped
    for (int i = 0; i < 5; i++) begin
      drive(0,0,0,0,1,3'(i + 1),2'(i + 1));
      tick();
      chk($sformatf("full_push_%0d", i), {12'd0, cmd_ready, q_count[1:0]},
          (i >= 3) ? {12'd0, 1'b0, 2'd0} : {12'd0, 1'b1, 2'(i + 1)});
      chk($sformatf("full_cnt_%0d", i), {12'd0, q_count}, (i >= 3) ? 15'd4 : 15'(i + 1));
    end
    // Pop while full: concurrent push ignored
    drive(0,0,1,0,1,3'b111,2'b11); tick();
    chk("full_pop", outs(), pk(0,0,1,1,0,0,1,3'd3,3'b001,2'b01));
    drive(0,0,0,0,0,3'b000,2'b00);
    for (int i = 0; i < 6; i++) tick();
    // Push and pop in the same cycle
    drive(0,0,1,0,1,3'b111,2'b11); tick();
    chk("push_pop_same", outs(), pk(0,0,1,1,0,0,1,3'd3,3'b010,2'b10));
    drive(0,0,0,0,0,3'b000,2'b00);
    for (int i = 0; i < 6; i++) tick();

    // Reset during the second shift cycle
    drive(0,0,1,0,0,3'b000,2'b00); tick();
    chk("rst_pre", outs(), pk(0,0,1,1,0,0,1,3'd2,3'b011,2'b11));
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), RstOut);
    tick();
    rst_n = 1'b1;
    execute = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rst_after_%0d", i), outs(), RstOut);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_op_sequencer.md
# serial_op_sequencer

Control and scheduling block for the 4-bit bit-serial logic processor datapath (A/B shift registers, F-selected logic unit, R-selected routing). It buffers operation commands (F, R) in a small queue, converts debounced LoadA/LoadB/Execute button levels into single-cycle datapath strobes, and drives the shift enable for exactly WIDTH cycles per operation. A Run_All mode drains the whole queue on one Execute press. It sits between the debounced switch/button inputs and the register/compute datapath.

## Interface
- WIDTH, 4: bits shifted per operation; shift counter width is $clog2(WIDTH+1).
- DEPTH, 4: command queue entries; must be a power of two, at least 2.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- LoadA  in  1  debounced level; a rising edge requests a load of A.
- LoadB  in  1  debounced level; a rising edge requests a load of B.
- Execute  in  1  debounced level; a rising edge starts execution.
- Run_All  in  1  sampled at each operation end; 1 continues with the next queued operation.
- Cmd_Valid  in  1  push request for one command.
- Cmd_F  in  3  logic function of the pushed command.
- Cmd_R  in  2  routing select of the pushed command.
- Cmd_Ready  out  1  queue not full; a push happens when Cmd_Valid and Cmd_Ready are both 1.
- Ld_A  out  1  one-cycle load strobe for register A.
- Ld_B  out  1  one-cycle load strobe for register B.
- Shift_En  out  1  datapath shift enable.
- F_Out  out  3  function of the active operation.
- R_Out  out  2  routing of the active operation.
- Busy  out  1  high in SHIFT and DONE.
- Done  out  1  one-cycle pulse after each operation completes.
- Err_Empty  out  1  one-cycle pulse when Execute rises and the queue is empty.
- Q_Count  out  $clog2(DEPTH+1)  number of queued commands.

## Operation
- Edge detection: LoadA, LoadB and Execute are each registered once. A rising edge is current input = 1 and registered input = 0.
- States:
  - IDLE: on an Execute edge, if the queue is non-empty, pop the head into F_Out/R_Out, clear the counter and go to SHIFT. If the queue is empty, pulse Err_Empty and go to HOLD.
  - IDLE: with no Execute edge, a LoadA edge pulses Ld_A and a LoadB edge pulses Ld_B. Both may pulse in the same cycle.
  - SHIFT: Shift_En = 1 and the counter increments. After WIDTH cycles, go to DONE.
  - DONE: Done = 1 for one cycle. If Run_All = 1 and the queue is non-empty, pop the next command and go to SHIFT. Otherwise go to HOLD.
  - HOLD: wait until Execute = 0, then go to IDLE. One press runs one operation, or one drain when Run_All = 1.
- Load edges outside IDLE, or in the same cycle as an Execute edge in IDLE, are dropped. Execute wins.
- F_Out and R_Out keep the last popped command and do not change outside a pop.
- Queue pushes are accepted in every state. A simultaneous push and pop leaves Q_Count unchanged. A push when full is ignored. Cmd_Ready = 0 in the full cycle even if a pop happens in that cycle.
- Queue pointers are log2(DEPTH) bits wide and wrap naturally.

## Timing
- Reset (asynchronous): state = IDLE, queue empty, counter = 0, edge registers = 0.
- Output reset values: Ld_A, Ld_B, Shift_En, Busy, Done and Err_Empty are 0. F_Out = 3'b000, R_Out = 2'b00, Q_Count = 0, Cmd_Ready = 1.
- Execute edge sampled at edge k: Shift_En is high for edges k+1 through k+WIDTH. Done is high at edge k+WIDTH+1.
- In Run_All mode there is exactly one DONE cycle between the shift bursts of consecutive operations.
- Ld_A and Ld_B assert in the cycle after the input rises, for exactly one cycle.
- All outputs are registered.
- Reset_n asserted mid-SHIFT: Shift_En drops immediately, the queue is cleared, and no Done pulse is produced.

## Structure
- Package seq_pkg holds:
  - state_t enum (IDLE, SHIFT, DONE, HOLD);
  - cmd_t packed struct {f[2:0], r[1:0]};
  - default WIDTH and DEPTH constants.
- Sub-module cmd_fifo (parameter DEPTH, cmd_t data): a synchronous FIFO with push/pop, full/empty and count outputs, using the same Clk/Reset_n.
- The FSM, counter and edge detectors live in serial_op_sequencer.

## Test plan
- Push {F=010, R=10}, then hold Execute for 11 cycles: Shift_En high for exactly 4 cycles, F_Out=010 and R_Out=10, one Done pulse, no second operation until Execute is released and pressed again.
- Press Execute with the queue empty: Err_Empty pulses once, Shift_En stays 0, and the block returns to IDLE after Execute falls.
- Hold LoadA for 4 cycles in IDLE: Ld_A is high for exactly 1 cycle. Press LoadB during SHIFT: Ld_B stays 0.
- Push {010,10}, {110,01} and {000,11} with Run_All=1, then press Execute once: three 4-cycle bursts separated by single Done cycles, F_Out sequence 010 → 110 → 000, Q_Count ends at 0.
- Push 5 commands with DEPTH=4: Cmd_Ready=0 after the 4th push, the 5th is dropped, and Q_Count=4. A push and pop in the same cycle keep the count unchanged.
- Assert Reset_n low during the 2nd shift cycle: all outputs return to their reset values asynchronously, Q_Count=0, and no Done pulse appears.
